cnn_layer_sequencer: RTL and testbench

CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

---
 rtl/cnn_layer_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: launches a chain of layer engines one at a time, then
// streams NUM_CLASSES signed scores and reports the argmax, cycle count and status.
// Latency: one LAUNCH cycle per layer, then the engine's done delay; one beat per
// ARGMAX cycle; FINISH/ERROR the cycle after the deciding event.
// Backpressure: score_ready is high only in ARGMAX, so beats offered elsewhere stall.
// Ports: clk/reset_n (async, active low); start (level) / abort; layer_start /
// layer_done per layer; score_valid/score_data/score_last/score_ready stream;
// busy/done/error/error_code status; predicted_class/max_score/cycle_count results.
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS     = 6,
  parameter int NUM_CLASSES    = 10,
  parameter int SCORE_W        = 32,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CYC_W          = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  output logic [NUM_LAYERS-1:0]     layer_start,
  input  logic [NUM_LAYERS-1:0]     layer_done,
  input  logic                      score_valid,
  input  logic signed [SCORE_W-1:0] score_data,
  input  logic                      score_last,
  output logic                      score_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [1:0]                error_code,
  output logic [((NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1)-1:0] predicted_class,
  output logic signed [SCORE_W-1:0] max_score,
  output logic [CYC_W-1:0]          cycle_count
);

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int CLS_W = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
  localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NUM_CLASSES - 1);
  localparam bit               WD_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0]      WD_LIM   = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_ARGMAX, S_FINISH, S_ERROR
  } state_t;

  state_t                    r_state, w_next;
  logic [IDX_W-1:0]          r_idx;
  logic [CLS_W-1:0]          r_beat;
  logic [31:0]               r_wdog;
  logic                      r_armed;
  logic [1:0]                r_err_code;
  logic [CLS_W-1:0]          r_pred;
  logic signed [SCORE_W-1:0] r_max;
  logic [CYC_W-1:0]          r_cyc;

  logic       w_timeout, w_last_beat, w_better;
  logic       w_run_clr, w_idx_inc, w_wd_clr, w_beat_take, w_err_set;
  logic [1:0] w_err_code;

  // Watchdog fires on the TIMEOUT_CYCLES-th counting cycle without progress.
  assign w_timeout   = WD_EN && (r_wdog == WD_LIM);
  assign w_last_beat = (r_beat == LAST_CLS);
  // Beat 0 always loads; later beats need a strictly larger score so ties keep the lower index.
  assign w_better    = (r_beat == '0) || (score_data > r_max);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_run_clr   = 1'b0;
    w_idx_inc   = 1'b0;
    w_wd_clr    = 1'b0;
    w_beat_take = 1'b0;
    w_err_set   = 1'b0;
    w_err_code  = 2'd0;
    layer_start = '0;
    busy        = 1'b0;
    score_ready = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && r_armed) begin
          w_next    = S_LAUNCH;
          w_run_clr = 1'b1;
        end
      end
      S_LAUNCH: begin
        busy        = 1'b1;
        layer_start = NUM_LAYERS'(1) << r_idx;
        w_next      = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (abort) begin
          w_next = S_IDLE;
        end else if (layer_done[r_idx]) begin
          // Completion beats a same-cycle timeout; the next window starts fresh.
          w_wd_clr = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_next = S_ARGMAX;
          end else begin
            w_idx_inc = 1'b1;
            w_next    = S_LAUNCH;
          end
        end else if (w_timeout) begin
          w_next     = S_ERROR;
          w_err_set  = 1'b1;
          w_err_code = 2'd1;
        end
      end
      S_ARGMAX: begin
        busy        = 1'b1;
        score_ready = 1'b1;
        if (abort) begin
          w_next = S_IDLE;
        end else if (score_valid) begin
          w_wd_clr = 1'b1;
          if (score_last != w_last_beat) begin
            w_next     = S_ERROR;
            w_err_set  = 1'b1;
            w_err_code = 2'd3;
          end else begin
            w_beat_take = 1'b1;
            if (w_last_beat) w_next = S_FINISH;
          end
        end else if (w_timeout) begin
          w_next     = S_ERROR;
          w_err_set  = 1'b1;
          w_err_code = 2'd2;
        end
      end
      S_FINISH: begin
        done = 1'b1;
        if (!start) w_next = S_IDLE;
      end
      S_ERROR: begin
        error = 1'b1;
        if (!start) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx      <= '0;
      r_beat     <= '0;
      r_wdog     <= '0;
      r_armed    <= 1'b0;
      r_err_code <= '0;
      r_pred     <= '0;
      r_max      <= '0;
      r_cyc      <= '0;
    end else begin
      // A run only launches after start has been seen low, so a start held
      // through reset, abort or a finished run cannot retrigger.
      if (!start)         r_armed <= 1'b1;
      else if (w_run_clr) r_armed <= 1'b0;

      if (w_run_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + IDX_W'(1);

      if (r_state != S_ARGMAX) r_beat <= '0;
      else if (w_beat_take)    r_beat <= r_beat + CLS_W'(1);

      if (w_wd_clr || !((r_state == S_WAIT) || (r_state == S_ARGMAX))) r_wdog <= '0;
      else                                                              r_wdog <= r_wdog + 32'd1;

      if (w_run_clr)      r_err_code <= '0;
      else if (w_err_set) r_err_code <= w_err_code;

      if (w_run_clr) begin
        r_pred <= '0;
        r_max  <= '0;
      end else if (w_beat_take && w_better) begin
        r_pred <= r_beat;
        r_max  <= score_data;
      end

      if (w_run_clr)                  r_cyc <= '0;
      else if (busy && (r_cyc != '1)) r_cyc <= r_cyc + CYC_W'(1);
    end
  end

  assign error_code      = r_err_code;
  assign predicted_class = r_pred;
  assign max_score       = r_max;
  assign cycle_count     = r_cyc;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: directed and randomized runs of cnn_layer_sequencer
// against a reference model of layer launching and argmax selection.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cnn_layer_sequencer;
  localparam int NL = 6;
  localparam int NC = 10;
  localparam int SW = 32;
  localparam int CW = 32;
  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 reset_n, start, abort;
  logic [NL-1:0]        layer_start, layer_done;
  logic                 score_valid, score_last, score_ready;
  logic signed [SW-1:0] score_data;
  logic                 busy, done, error;
  logic [1:0]           error_code;
  logic [3:0]           predicted_class;
  logic signed [SW-1:0] max_score;
  logic [CW-1:0]        cycle_count;

  always #5 clk = ~clk;

  cnn_layer_sequencer #(
    .NUM_LAYERS(NL), .NUM_CLASSES(NC), .SCORE_W(SW), .TIMEOUT_CYCLES(TO), .CYC_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .layer_start(layer_start), .layer_done(layer_done),
    .score_valid(score_valid), .score_data(score_data), .score_last(score_last),
    .score_ready(score_ready), .busy(busy), .done(done), .error(error),
    .error_code(error_code), .predicted_class(predicted_class),
    .max_score(max_score), .cycle_count(cycle_count)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Layer-engine and score-source model state.
  logic signed [SW-1:0] sc[$];
  int  ls_seq[$];
  int  cnt[NL];
  int  busy_cyc, beat_no, last_pos, cur_layer;
  int  dly_lo, dly_hi, hang_layer, abort_layer, vmode, gap;
  bit  phase, noise_en, multi_hot;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs, then drive inputs for the next rising edge.
  task automatic step();
    logic [NL-1:0] d;
    bit v;
    @(negedge clk);
    if (busy) busy_cyc++;
    if ($countones(layer_start) > 1) multi_hot = 1'b1;
    d = '0;
    for (int i = 0; i < NL; i++) begin
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) d[i] = 1'b1;
      end
    end
    if (abort_layer >= 0) abort = d[abort_layer];
    else                  abort = 1'b0;
    // Spurious done on already-finished layers must be ignored.
    if (noise_en && cur_layer > 0 && $urandom_range(2, 0) == 0)
      d[$urandom_range(cur_layer - 1, 0)] = 1'b1;
    for (int i = 0; i < NL; i++) begin
      if (layer_start[i]) begin
        ls_seq.push_back(i);
        cur_layer = i;
        if (i != hang_layer) cnt[i] = $urandom_range(dly_hi, dly_lo);
      end
    end
    layer_done = d;
    v = 1'b0;
    if (beat_no < sc.size()) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = phase;
        default: v = ($urandom_range(1, 0) == 1) || (gap >= 2);
      endcase
    end
    phase       = ~phase;
    gap         = v ? 0 : gap + 1;
    score_valid = v;
    score_data  = (beat_no < sc.size()) ? sc[beat_no] : SW'($urandom);
    score_last  = v && (beat_no == last_pos);
    if (v && score_ready && !abort) beat_no++;
  endtask

  task automatic begin_run(input int lpos);
    ls_seq.delete();
    busy_cyc  = 0;
    beat_no   = 0;
    cur_layer = 0;
    multi_hot = 1'b0;
    last_pos  = lpos;
    phase     = 1'b1;
    gap       = 0;
    foreach (cnt[i]) cnt[i] = 0;
    start = 1'b1;
  endtask

  task automatic end_run();
    start = 1'b0;
    step();
    step();
  endtask

  task automatic run_to_end(input string tag);
    int n = 0;
    while (!(done || error) && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_ended"}, 64'(done || error), 64'd1);
  endtask

  // Winning score is the maximum of the first n beats; winner is its first occurrence.
  task automatic ref_argmax(input int n, output int idx, output logic signed [SW-1:0] mx);
    mx = sc[0];
    for (int k = 1; k < n; k++) if (sc[k] > mx) mx = sc[k];
    idx = -1;
    for (int k = 0; k < n; k++) if (idx < 0 && sc[k] == mx) idx = k;
  endtask

  function automatic bit seq_ok(input int n);
    if (ls_seq.size() != n) return 1'b0;
    for (int i = 0; i < n; i++) if (ls_seq[i] != i) return 1'b0;
    return 1'b1;
  endfunction

  task automatic rand_scores(input int lo, input int hi);
    sc.delete();
    for (int k = 0; k < NC; k++) sc.push_back(SW'(int'($urandom_range(hi - lo, 0)) + lo));
  endtask

  int                   e_idx;
  logic signed [SW-1:0] e_max;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; layer_done = '0;
    score_valid = 1'b0; score_data = '0; score_last = 1'b0;
    abort_layer = -1; hang_layer = -1; noise_en = 1'b0; vmode = 0;
    dly_lo = 3; dly_hi = 3; busy_cyc = 0; beat_no = 0; last_pos = NC - 1;
    cur_layer = 0; gap = 0; phase = 1'b0; multi_hot = 1'b0;
    foreach (cnt[i]) cnt[i] = 0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_layer_start", 64'(layer_start), 64'd0);
    chk("rst_ready", 64'(score_ready), 64'd0);
    chk("rst_cycles", 64'(cycle_count), 64'd0);
    reset_n = 1'b1;
    step();
    step();

    // Nominal run: fixed 3-cycle layers, score every cycle.
    sc = '{5, -2, 40, 7, 40, 0, 1, -9, 3, 12};
    begin_run(NC - 1);
    run_to_end("t1");
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_error", 64'(error), 64'd0);
    chk("t1_class", 64'(predicted_class), 64'd2);
    chk("t1_max", 64'(max_score), 64'(32'sd40));
    chk("t1_cycles_const", 64'(cycle_count), 64'd34);
    chk("t1_cycles_obs", 64'(cycle_count), 64'(busy_cyc));
    chk("t1_layer_order", 64'(seq_ok(NL)), 64'd1);
    chk("t1_onehot", 64'(multi_hot), 64'd0);
    repeat (3) step();
    chk("t1_hold_done", 64'(done), 64'd1);
    chk("t1_no_retrigger", 64'(ls_seq.size()), 64'(NL));
    end_run();
    chk("t1_idle_done", 64'(done), 64'd0);

    // All-negative scores, valid on alternate cycles, tie keeps lower index.
    sc = '{-50, -3, -3, -80, -7, -100, -3, -20, -60, -9};
    vmode = 1;
    begin_run(NC - 1);
    run_to_end("t2");
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_class", 64'(predicted_class), 64'd1);
    chk("t2_max", 64'(max_score), 64'(-32'sd3));
    chk("t2_cycles", 64'(cycle_count), 64'(busy_cyc));
    end_run();

    // Layer 3 never completes: layer timeout.
    vmode = 0;
    hang_layer = 3;
    begin_run(NC - 1);
    run_to_end("t3");
    chk("t3_error", 64'(error), 64'd1);
    chk("t3_code", 64'(error_code), 64'd1);
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_layers", 64'(seq_ok(4)), 64'd1);
    end_run();
    chk("t3_idle_error", 64'(error), 64'd0);
    hang_layer = -1;

    // score_last on beat 6: misaligned, result from beats 0..5 only.
    rand_scores(-100, 100);
    begin_run(6);
    run_to_end("t4");
    ref_argmax(6, e_idx, e_max);
    chk("t4_error", 64'(error), 64'd1);
    chk("t4_code", 64'(error_code), 64'd3);
    chk("t4_class", 64'(predicted_class), 64'(e_idx));
    chk("t4_max", 64'(max_score), 64'(e_max));
    end_run();

    // Abort coincident with layer_done[2].
    abort_layer = 2;
    begin_run(NC - 1);
    begin
      int  n = 0;
      bit  seen = 1'b0;
      while (n < 200) begin
        step();
        n++;
        if (busy) seen = 1'b1;
        else if (seen) break;
      end
      chk("t5_aborted", 64'(seen && !busy), 64'd1);
    end
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_error", 64'(error), 64'd0);
    abort_layer = -1;
    repeat (4) step();
    chk("t5_no_layer3", 64'(seq_ok(3)), 64'd1);
    chk("t5_stays_idle", 64'(busy), 64'd0);
    end_run();

    // No scores offered: score timeout.
    sc.delete();
    begin_run(NC - 1);
    run_to_end("t6");
    chk("t6_error", 64'(error), 64'd1);
    chk("t6_code", 64'(error_code), 64'd2);
    end_run();

    // Reset pulse while in ARGMAX.
    rand_scores(-1000, 1000);
    begin_run(NC - 1);
    begin
      int n = 0;
      while (!(score_ready && beat_no >= 3) && n < 200) begin
        step();
        n++;
      end
      chk("t7_reached_argmax", 64'(score_ready), 64'd1);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("t7_rst_busy", 64'(busy), 64'd0);
    chk("t7_rst_ready", 64'(score_ready), 64'd0);
    chk("t7_rst_done_err", 64'({done, error, error_code}), 64'd0);
    chk("t7_rst_class", 64'(predicted_class), 64'd0);
    chk("t7_rst_max", 64'(max_score), 64'd0);
    chk("t7_rst_cycles", 64'(cycle_count), 64'd0);
    chk("t7_rst_layer_start", 64'(layer_start), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    foreach (cnt[i]) cnt[i] = 0;
    repeat (3) step();
    chk("t7_held_start_no_run", 64'(busy), 64'd0);
    end_run();
    begin_run(NC - 1);
    run_to_end("t7b");
    ref_argmax(NC, e_idx, e_max);
    chk("t7b_done", 64'(done), 64'd1);
    chk("t7b_class", 64'(predicted_class), 64'(e_idx));
    chk("t7b_max", 64'(max_score), 64'(e_max));
    end_run();

    // Randomized runs: narrow score range for ties, random delays, gaps and noise.
    vmode = 2;
    noise_en = 1'b1;
    dly_lo = 1;
    dly_hi = 6;
    for (int r = 0; r < 5; r++) begin
      rand_scores(-4, 4);
      begin_run(NC - 1);
      run_to_end("tr");
      ref_argmax(NC, e_idx, e_max);
      chk("tr_done", 64'(done), 64'd1);
      chk("tr_class", 64'(predicted_class), 64'(e_idx));
      chk("tr_max", 64'(max_score), 64'(e_max));
      chk("tr_cycles", 64'(cycle_count), 64'(busy_cyc));
      chk("tr_layers", 64'(seq_ok(NL)), 64'd1);
      chk("tr_onehot", 64'(multi_hot), 64'd0);
      end_run();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
